serial_link_phy_rx_aligner: RTL and testbench



---
 rtl/serial_link_pkg.sv | 15 +
 rtl/serial_link_align_mux.sv | 36 +++
 rtl/serial_link_phy_rx_aligner.sv | 131 +++++++++++++
 tb/tb_serial_link_phy_rx_aligner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link PHY: aligner state encoding and training word.
package serial_link_pkg;

   localparam int unsigned AlignCntW = 4;

   // Default training word for a 16-bit (8-lane) channel.
   localparam logic [15:0] AlignTrainPattern = 16'hA55A;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } align_state_e;

endpackage

// File: rtl/serial_link_align_mux.sv
// Half-word realignment: keeps the previous upper half and builds both candidate words.
module serial_link_align_mux
   import serial_link_pkg::*;
#(
   parameter int unsigned NumLanes = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  acc_i,
   input  logic                  offset_i,
   input  logic [2*NumLanes-1:0] in_data_i,
   output logic [2*NumLanes-1:0] cand0_o,
   output logic [2*NumLanes-1:0] cand1_o,
   output logic [2*NumLanes-1:0] sel_o
);

   localparam int unsigned H = NumLanes;
   localparam int unsigned W = 2 * NumLanes;

   logic [H-1:0] last_hi_q;

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_hi_q <= '0;
      end else if (acc_i) begin
         last_hi_q <= in_data_i[W-1:H];
      end
   end

   // The earlier half of a shifted word is the previous word's upper half.
   assign cand0_o = in_data_i;
   assign cand1_o = {in_data_i[H-1:0], last_hi_q};
   assign sel_o   = offset_i ? cand1_o : cand0_o;

endmodule

// File: rtl/serial_link_phy_rx_aligner.sv
// RX word aligner: finds the training word, locks the half-word offset, then forwards realigned words.
// Optional fail statistics counter enabled by defining SERIAL_LINK_ALIGN_STATS_EN.
module serial_link_phy_rx_aligner
   import serial_link_pkg::*;
#(
   parameter int unsigned           NumLanes     = 8,
   parameter logic [2*NumLanes-1:0] TrainPattern = serial_link_pkg::AlignTrainPattern,
   parameter int unsigned           LockCount    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  resync_i,
   input  logic [2*NumLanes-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [2*NumLanes-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  locked_o,
   output logic                  offset_o,
   output logic [7:0]            align_fail_cnt_o
);

   localparam int unsigned W = 2 * NumLanes;
   localparam logic [AlignCntW-1:0] LockCnt = AlignCntW'(LockCount);

   align_state_e         state_q;
   logic                 offset_q;
   logic [AlignCntW-1:0] match_cnt_q;
   logic [AlignCntW-1:0] match_cnt_inc;
   logic                 have_prev_q;
   logic                 acc;
   logic [W-1:0]         cand0;
   logic [W-1:0]         cand1;
   logic [W-1:0]         sel;

   serial_link_align_mux #(
      .NumLanes (NumLanes)
   ) u_align_mux (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .acc_i     (acc),
      .offset_i  (offset_q),
      .in_data_i (in_data_i),
      .cand0_o   (cand0),
      .cand1_o   (cand1),
      .sel_o     (sel)
   );

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      in_ready_o  = 1'b1;
      out_valid_o = 1'b0;
      if (state_q == LOCKED) begin
         in_ready_o  = out_ready_i;
         out_valid_o = in_valid_i;
      end
      // A word presented with resync is neither consumed nor offered downstream.
      if (resync_i) begin
         in_ready_o  = 1'b0;
         out_valid_o = 1'b0;
      end
   end

   assign acc           = in_valid_i & in_ready_o;
   assign match_cnt_inc = match_cnt_q + 1'b1;
   assign out_data_o    = sel;
   assign locked_o      = (state_q == LOCKED);
   assign offset_o      = offset_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= SEARCH;
         offset_q    <= 1'b0;
         match_cnt_q <= '0;
         have_prev_q <= 1'b0;
      end else if (resync_i) begin
         state_q     <= SEARCH;
         match_cnt_q <= '0;
         have_prev_q <= 1'b0;
      end else if (acc) begin
         have_prev_q <= 1'b1;
         case (state_q)
            SEARCH: begin
               if (cand0 == TrainPattern) begin
                  offset_q    <= 1'b0;
                  match_cnt_q <= AlignCntW'(1);
                  state_q     <= (LockCnt == AlignCntW'(1)) ? LOCKED : CONFIRM;
               end else if (have_prev_q && (cand1 == TrainPattern)) begin
                  offset_q    <= 1'b1;
                  match_cnt_q <= AlignCntW'(1);
                  state_q     <= (LockCnt == AlignCntW'(1)) ? LOCKED : CONFIRM;
               end
            end
            CONFIRM: begin
               if (sel == TrainPattern) begin
                  match_cnt_q <= match_cnt_inc;
                  if (match_cnt_inc == LockCnt) begin
                     state_q <= LOCKED;
                  end
               end else begin
                  // The mismatching word is discarded, not searched again.
                  state_q     <= SEARCH;
                  match_cnt_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_LINK_ALIGN_STATS_EN
   logic       fail_evt;
   logic [7:0] fail_cnt_q;

   assign fail_evt = acc & ~resync_i & (state_q == CONFIRM) & (sel != TrainPattern);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fail_cnt_q <= '0;
      end else if (fail_evt && (fail_cnt_q != 8'hFF)) begin
         fail_cnt_q <= fail_cnt_q + 8'd1;
      end
   end

   assign align_fail_cnt_o = fail_cnt_q;
`else
   assign align_fail_cnt_o = '0;
`endif

endmodule

// File: tb/tb_serial_link_phy_rx_aligner.sv
// Self-checking bench for serial_link_phy_rx_aligner; forwarded words are checked against a scoreboard.
module tb_serial_link_phy_rx_aligner;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        resync_i = 1'b0;
   logic [15:0] in_data_i = '0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [15:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic        locked_o;
   logic        offset_o;
   logic [7:0]  align_fail_cnt_o;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;
   logic [15:0] exp_q[$];

`ifdef SERIAL_LINK_ALIGN_STATS_EN
   localparam logic [7:0] ExpFailAfterFalseStart = 8'd1;
`else
   localparam logic [7:0] ExpFailAfterFalseStart = 8'd0;
`endif

   serial_link_phy_rx_aligner dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .resync_i         (resync_i),
      .in_data_i        (in_data_i),
      .in_valid_i       (in_valid_i),
      .in_ready_o       (in_ready_o),
      .out_data_o       (out_data_o),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .locked_o         (locked_o),
      .offset_o         (offset_o),
      .align_fail_cnt_o (align_fail_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard monitor: every handshake on the output side must match the next expected word.
   always @(negedge clk_i) begin
      if (!rst_i && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 32'd1);
         else check("out_data", {16'h0, out_data_o}, {16'h0, exp_q.pop_front()});
      end
   end

   // Drive one word and hold it until accepted; returns 1 ns after the accepting edge.
   task automatic send(input logic [15:0] w);
      int cyc;
      in_data_i  = w;
      in_valid_i = 1'b1;
      cyc = 0;
      forever begin
         @(negedge clk_i);
         if (in_ready_o) break;
         cyc++;
         if (cyc > 20) begin
            check("accept_timeout", 32'(cyc), 32'd0);
            break;
         end
      end
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic resync_pulse();
      resync_i = 1'b1;
      @(posedge clk_i);
      #1;
      resync_i = 1'b0;
   endtask

   task automatic train_offset0(input string tag);
      for (int i = 0; i < 4; i++) begin
         send(16'hA55A);
         if (i == 2) check({tag, "_not_yet_locked"}, {31'h0, locked_o}, 32'd0);
      end
      check({tag, "_locked"}, {31'h0, locked_o}, 32'd1);
      check({tag, "_offset"}, {31'h0, offset_o}, 32'd0);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_locked", {31'h0, locked_o}, 32'd0);
      check("rst_offset", {31'h0, offset_o}, 32'd0);
      check("rst_out_valid", {31'h0, out_valid_o}, 32'd0);
      check("rst_fail_cnt", {24'h0, align_fail_cnt_o}, 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("rst_in_ready", {31'h0, in_ready_o}, 32'd1);

      // 1: offset-0 lock, then one data word
      train_offset0("t1");
      exp_q.push_back(16'h1234);
      send(16'h1234);

      // 2: offset-1 lock on a half-shifted stream
      resync_pulse();
      send(16'h5A00);
      for (int i = 0; i < 4; i++) begin
         send(16'h5AA5);
         if (i == 2) check("t2_not_yet_locked", {31'h0, locked_o}, 32'd0);
      end
      check("t2_locked", {31'h0, locked_o}, 32'd1);
      check("t2_offset", {31'h0, offset_o}, 32'd1);
      exp_q.push_back(16'h345A);
      send(16'h1234);

      // 4: backpressure while locked at offset 1
      out_ready_i = 1'b0;
      in_data_i   = 16'hBEEF;
      in_valid_i  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("t4_in_ready_held", {31'h0, in_ready_o}, 32'd0);
         check("t4_out_valid", {31'h0, out_valid_o}, 32'd1);
         check("t4_out_data_held", {16'h0, out_data_o}, 32'h0000EF12);
      end
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b1;
      exp_q.push_back(16'hEF12);
      send(16'hBEEF);
      exp_q.push_back(16'h01BE);
      send(16'h0001);

      // 5: resync coincident with a valid word
      @(posedge clk_i);
      #1;
      in_data_i  = 16'h2222;
      in_valid_i = 1'b1;
      resync_i   = 1'b1;
      @(negedge clk_i);
      check("t5_word_not_taken", {31'h0, in_ready_o}, 32'd0);
      @(posedge clk_i);
      #1;
      resync_i   = 1'b0;
      in_valid_i = 1'b0;
      check("t5_unlocked", {31'h0, locked_o}, 32'd0);
      check("t5_offset_held", {31'h0, offset_o}, 32'd1);
      train_offset0("t5");
      exp_q.push_back(16'hC0DE);
      send(16'hC0DE);

      // 3: false start in CONFIRM
      resync_pulse();
      send(16'hA55A);
      send(16'hA55A);
      send(16'h0000);
      check("t3_back_to_search", {31'h0, locked_o}, 32'd0);
      check("t3_fail_cnt", {24'h0, align_fail_cnt_o}, {24'h0, ExpFailAfterFalseStart});
      train_offset0("t3");
      exp_q.push_back(16'h5555);
      send(16'h5555);

      // 6: async reset mid-CONFIRM, asserted between edges
      resync_pulse();
      send(16'hA55A);
      send(16'hA55A);
      check("t6_cnt_before", {28'h0, dut.match_cnt_q}, 32'd2);
      in_data_i  = 16'hA55A;
      in_valid_i = 1'b1;
      #2;
      rst_i = 1'b1;
      #1;
      check("t6_locked", {31'h0, locked_o}, 32'd0);
      check("t6_out_valid", {31'h0, out_valid_o}, 32'd0);
      check("t6_match_cnt", {28'h0, dut.match_cnt_q}, 32'd0);
      check("t6_have_prev", {31'h0, dut.have_prev_q}, 32'd0);
      check("t6_fail_cnt", {24'h0, align_fail_cnt_o}, 32'd0);
      in_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      train_offset0("t6");
      exp_q.push_back(16'h7777);
      send(16'h7777);

      @(posedge clk_i);
      #1;
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
